axis_tx_frame_fifo: RTL and testbench

- Store-and-forward byte FIFO placed directly upstream of the GMII frame transmitter. It feeds that transmitter's 8-bit AXI-stream input.
- A frame is released downstream only after its tlast byte has been stored. Once a frame starts, output tvalid never drops mid-frame, so the transmitter never sees an underrun (which it would otherwise convert into tx_er).
- Frames that overflow storage are discarded whole.

---
 rtl/axis_tx_frame_fifo_if.sv | 33 +++
 rtl/axis_tx_frame_fifo.sv | 136 +++++++++++++
 tb/tb_axis_tx_frame_fifo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axis_tx_frame_fifo_if.sv
// rtl/axis_tx_frame_fifo_if.sv - byte-stream and status signals of the store-and-forward TX frame FIFO
interface axis_tx_frame_fifo_if;
  logic [7:0] input_axis_tdata;
  logic       input_axis_tvalid;
  logic       input_axis_tready;
  logic       input_axis_tlast;
  logic       input_axis_tuser;
  logic [7:0] output_axis_tdata;
  logic       output_axis_tvalid;
  logic       output_axis_tready;
  logic       output_axis_tlast;
  logic       output_axis_tuser;
  logic       status_overflow;
  logic       status_bad_frame;
  logic       status_good_frame;

  // slave: the FIFO itself; master: the frame source / sink around it
  modport slave (
    input  input_axis_tdata, input_axis_tvalid, input_axis_tlast, input_axis_tuser,
    output input_axis_tready,
    output output_axis_tdata, output_axis_tvalid, output_axis_tlast, output_axis_tuser,
    input  output_axis_tready,
    output status_overflow, status_bad_frame, status_good_frame
  );

  modport master (
    output input_axis_tdata, input_axis_tvalid, input_axis_tlast, input_axis_tuser,
    input  input_axis_tready,
    input  output_axis_tdata, output_axis_tvalid, output_axis_tlast, output_axis_tuser,
    output output_axis_tready,
    input  status_overflow, status_bad_frame, status_good_frame
  );
endinterface

// File: rtl/axis_tx_frame_fifo.sv
// rtl/axis_tx_frame_fifo.sv - store-and-forward byte FIFO releasing only whole committed frames
// Optional: define AXIS_TX_FIFO_DROP_BAD_EN to discard frames flagged with tuser at tlast.
module axis_tx_frame_fifo #(
  parameter int ADDR_WIDTH = 12
) (
  input logic                  clk,
  input logic                  rstn,
  axis_tx_frame_fifo_if.slave  fifo_io
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(1) << ADDR_WIDTH;

  logic [9:0]    mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_q, commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          drop_q, drop_d;
  logic          in_ready_q;
  logic [9:0]    out_word_q, out_word_d;
  logic          out_valid_q, out_valid_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;
  logic          good_q, good_d;

  logic          in_hs;
  logic          full;
  logic          wr_en;
  logic [9:0]    wr_word;
  logic          data_avail;
  logic          load;

  assign in_hs = fifo_io.input_axis_tvalid & in_ready_q;
  // Uses rd_ptr before any same-cycle read, so full is conservative by one byte at most.
  assign full  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

`ifdef AXIS_TX_FIFO_DROP_BAD_EN
  assign wr_word = {1'b0, fifo_io.input_axis_tlast, fifo_io.input_axis_tdata};
`else
  assign wr_word = {fifo_io.input_axis_tuser, fifo_io.input_axis_tlast, fifo_io.input_axis_tdata};
`endif

  assign data_avail = rd_ptr_q != commit_q;
  assign load       = data_avail & (~out_valid_q | fifo_io.output_axis_tready);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    commit_d    = commit_q;
    rd_ptr_d    = rd_ptr_q;
    drop_d      = drop_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    ovf_d       = 1'b0;
    bad_d       = 1'b0;
    good_d      = 1'b0;
    wr_en       = 1'b0;

    if (in_hs) begin
      if (!drop_q && !full) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (full) begin
        drop_d = 1'b1;
      end
      if (fifo_io.input_axis_tlast) begin
        drop_d = 1'b0;
        bad_d  = fifo_io.input_axis_tuser;
        if (drop_q || full) begin
          wr_ptr_d = commit_q;
          ovf_d    = 1'b1;
`ifdef AXIS_TX_FIFO_DROP_BAD_EN
        end else if (fifo_io.input_axis_tuser) begin
          wr_ptr_d = commit_q;
`endif
        end else begin
          commit_d = wr_ptr_q + PW'(1);
          good_d   = 1'b1;
        end
      end
    end

    if (load) begin
      out_word_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end else if (fifo_io.output_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      commit_q    <= '0;
      rd_ptr_q    <= '0;
      drop_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      good_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      commit_q    <= commit_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_q      <= drop_d;
      in_ready_q  <= 1'b1;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      good_q      <= good_d;
    end
  end

  assign fifo_io.input_axis_tready  = in_ready_q;
  assign fifo_io.output_axis_tdata  = out_word_q[7:0];
  assign fifo_io.output_axis_tlast  = out_word_q[8];
  assign fifo_io.output_axis_tuser  = out_word_q[9];
  assign fifo_io.output_axis_tvalid = out_valid_q;
  assign fifo_io.status_overflow    = ovf_q;
  assign fifo_io.status_bad_frame   = bad_q;
  assign fifo_io.status_good_frame  = good_q;

endmodule

// File: tb/tb_axis_tx_frame_fifo.sv
// tb/tb_axis_tx_frame_fifo.sv - scoreboard bench for axis_tx_frame_fifo (64-byte storage)
module tb_axis_tx_frame_fifo;

  localparam int AW = 6;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  axis_tx_frame_fifo_if bus ();

  axis_tx_frame_fifo #(.ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .fifo_io (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_good = 0, n_badf = 0, n_ovf = 0;
  logic [9:0] expq [$];
  logic [9:0] w;

  logic rdy_man  = 1'b1;
  logic tog      = 1'b0;
  logic toggle_en = 1'b0;

  assign bus.output_axis_tready = toggle_en ? tog : rdy_man;

  always @(posedge clk) begin
    #1 tog = ~tog;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.status_good_frame) n_good++;
      if (bus.status_bad_frame)  n_badf++;
      if (bus.status_overflow)   n_ovf++;
      if (bus.output_axis_tvalid && bus.output_axis_tready) begin
        chk("sb_nonempty", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          w = expq.pop_front();
          chk("out_word", {22'd0, bus.output_axis_tuser, bus.output_axis_tlast, bus.output_axis_tdata}, {22'd0, w});
        end
      end
    end
  end

  task automatic send_frame(input int len, input int base, input bit user_last, input bit keep);
    logic [9:0] fr [$];
    logic [7:0] d;
    chk("in_ready", 32'(bus.input_axis_tready), 32'd1);
    for (int i = 0; i < len; i++) begin
      d = 8'(base + i);
      bus.input_axis_tvalid = 1'b1;
      bus.input_axis_tdata  = d;
      bus.input_axis_tlast  = (i == len - 1);
      bus.input_axis_tuser  = user_last && (i == len - 1);
      fr.push_back({bus.input_axis_tuser, bus.input_axis_tlast, d});
      @(posedge clk); #1;
    end
    bus.input_axis_tvalid = 1'b0;
    bus.input_axis_tlast  = 1'b0;
    bus.input_axis_tuser  = 1'b0;
    if (keep) begin
      foreach (fr[i]) expq.push_back(fr[i]);
    end
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 4000 && expq.size() > 0; c++) @(posedge clk);
    chk(tag, 32'(expq.size()), 32'd0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, b0, o0;
    bit drop_bad;
`ifdef AXIS_TX_FIFO_DROP_BAD_EN
    drop_bad = 1'b1;
`else
    drop_bad = 1'b0;
`endif
    bus.input_axis_tvalid = 1'b0;
    bus.input_axis_tdata  = 8'h00;
    bus.input_axis_tlast  = 1'b0;
    bus.input_axis_tuser  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.output_axis_tvalid), 32'd0);
    chk("rst_in_ready",  32'(bus.input_axis_tready), 32'd0);
    chk("rst_status", {29'd0, bus.status_overflow, bus.status_bad_frame, bus.status_good_frame}, 32'd0);
    rstn = 1'b1;
    #1 chk("ready_pre_edge", 32'(bus.input_axis_tready), 32'd0);
    @(posedge clk); #1;
    chk("ready_post_edge", 32'(bus.input_axis_tready), 32'd1);

    // full-depth frame passes, latency from tlast edge
    g0 = n_good;
    send_frame(64, 0, 1'b0, 1'b1);
    chk("t1_valid_edge_k", 32'(bus.output_axis_tvalid), 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_edge_k1", 32'(bus.output_axis_tvalid), 32'd1);
    drain("t1_drain");
    chk("t1_good", 32'(n_good - g0), 32'd1);

    // overflow drops whole frame, next frame unaffected
    rdy_man = 1'b0;
    o0 = n_ovf; g0 = n_good;
    send_frame(65, 8'h40, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("t2_ovf", 32'(n_ovf - o0), 32'd1);
    chk("t2_no_valid", 32'(bus.output_axis_tvalid), 32'd0);
    send_frame(10, 8'h80, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("t2_valid_stalled", 32'(bus.output_axis_tvalid), 32'd1);
    rdy_man = 1'b1;
    drain("t2_drain");
    chk("t2_good", 32'(n_good - g0), 32'd1);

    // bad frame
    g0 = n_good; b0 = n_badf;
    send_frame(20, 8'hA0, 1'b1, !drop_bad);
    drain("t3_drain");
    chk("t3_bad", 32'(n_badf - b0), 32'd1);
    chk("t3_good", 32'(n_good - g0), drop_bad ? 32'd0 : 32'd1);

    // output backpressure toggling with back-to-back frames
    toggle_en = 1'b1;
    g0 = n_good;
    send_frame(1, 8'h11, 1'b0, 1'b1);
    send_frame(60, 8'h20, 1'b0, 1'b1);
    send_frame(1, 8'hEE, 1'b0, 1'b1);
    drain("t4_drain");
    toggle_en = 1'b0;
    chk("t4_good", 32'(n_good - g0), 32'd3);

    // reset mid-frame with a stored frame
    rdy_man = 1'b0;
    send_frame(10, 8'h30, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      bus.input_axis_tvalid = 1'b1;
      bus.input_axis_tdata  = 8'(8'h50 + i);
      bus.input_axis_tlast  = 1'b0;
      @(posedge clk); #1;
    end
    chk("t5_valid_before_rst", 32'(bus.output_axis_tvalid), 32'd1);
    bus.input_axis_tvalid = 1'b0;
    #2 rstn = 1'b0;
    #1 chk("t5_valid_in_rst", 32'(bus.output_axis_tvalid), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    rdy_man = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t5_no_stale", 32'(bus.output_axis_tvalid), 32'd0);
    send_frame(8, 8'hC0, 1'b0, 1'b1);
    drain("t5_drain");

    // fill to DEPTH-1 then stream across pointer wrap
    rdy_man = 1'b0;
    o0 = n_ovf; g0 = n_good;
    send_frame(31, 8'h00, 1'b0, 1'b1);
    send_frame(32, 8'h40, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("t6_ovf_fill", 32'(n_ovf - o0), 32'd0);
    rdy_man = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(30, 8'h80 + f * 30, 1'b0, 1'b1);
    drain("t6_drain");
    chk("t6_ovf", 32'(n_ovf - o0), 32'd0);
    chk("t6_good", 32'(n_good - g0), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
